mem_copy_dma: RTL and testbench
===============================

# mem_copy_dma

Block-copy initiator for the user-space data memory port. Given a source address, destination address and word count, it issues alternating read and write requests on the memory request/stall interface, honouring the responder's stall, and pulses `done` when the last word has been written. It sits beside the CPU as a second master in front of the data memory; the arbiter is external to this block.

## Interface

**Parameters**
- `WIDTH`, default 16: word-address width. Also the width of the length counter.

**Ports** (clock and reset first)
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: one-cycle request to begin a copy. Sampled only in IDLE.
- `src_addr`, in, WIDTH: first source word address. Latched on an accepted `start`.
- `dst_addr`, in, WIDTH: first destination word address. Latched on an accepted `start`.
- `len`, in, WIDTH: number of words to copy, 0 to 2^WIDTH-1. Latched on an accepted `start`.
- `busy`, out, 1: high while in RD or WR.
- `done`, out, 1: one-cycle pulse when the copy completes.
- `mem_address`, out, WIDTH: request address.
- `mem_data_out`, out, 32: write data. Connects to the memory's `data_in`.
- `mem_read`, out, 1: read request.
- `mem_write`, out, 1: write request.
- `mem_data_in`, in, 32: read data. Connects to the memory's `data_out`.
- `mem_stall`, in, 1: responder stall. High means the request is not yet complete.

## Operation

**Memory protocol (initiator side)**
- A request is `mem_read` or `mem_write` high, never both.
- The request, `mem_address` and `mem_data_out` are held constant while `mem_stall` is high.
- The request completes in the first cycle it is asserted with `mem_stall` low.
- On a read, `mem_data_in` is captured in that completion cycle.
- Each request is deasserted or changed in the cycle after completion. The block never relies on a fixed stall count.

**States**
- IDLE
  - All requests low.
  - `start`=1: latch `src_addr`, `dst_addr` and `len` into `src_ptr`, `dst_ptr` and `remaining`.
  - Go to DONE if `len`==0, else go to RD.
- RD
  - Drive `mem_read`=1 and `mem_address`=`src_ptr`.
  - On completion: capture `mem_data_in` into `data_reg`, increment `src_ptr`, go to WR.
- WR
  - Drive `mem_write`=1, `mem_address`=`dst_ptr` and `mem_data_out`=`data_reg`.
  - On completion: increment `dst_ptr` and decrement `remaining`.
  - Go to DONE if `remaining` was 1, else go to RD.
- DONE
  - `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE.
  - `start` in DONE is ignored.

**Arithmetic and boundaries**
- Pointers are WIDTH bits and wrap modulo 2^WIDTH: address 0xFFFF is followed by 0x0000 for WIDTH=16.
- Copy is strictly ascending, one word at a time. With overlapping ranges and `dst` > `src`, the destination receives propagated data. This is the defined behaviour; it is not detected or flagged.
- `start` while `busy`=1 is ignored, and the latched operands are unchanged.
- `rst`=1 in any state: the next state is IDLE.
  - `mem_read`, `mem_write`, `busy` and `done` are low from the following cycle.
  - A partially completed copy is abandoned, with no rollback.
- Reset value of every output:
  - `busy`, `done`, `mem_read`, `mem_write`: 0.
  - `mem_address`, `mem_data_out`: 0.
  - Internal registers: 0.
- `mem_address` and `mem_data_out` are 0 whenever no request is asserted.

## Timing

- `start` is accepted at the edge ending cycle 0. RD is driven from cycle 1.
- With the standard one-stall-cycle responder, each word takes 4 cycles: RD stalled, RD complete, WR stalled, WR complete.
- For `len`=N>0:
  - `busy` is high in cycles 1 through 4N.
  - `done` pulses in cycle 4N+1.
  - A new `start` is accepted from cycle 4N+2.
- For `len`=0: `done` pulses in cycle 1 and no memory request is issued.
- For a responder with extra stall cycles, latency grows by one cycle per extra stall cycle.
- All outputs are registered or decoded from state registers. There is no combinational path from `mem_stall` or `mem_data_in` to any output.

## Configuration

- Macro: `MEM_DMA_FILL_EN`.
- When defined, two extra inputs are added:
  - `fill`, in, 1: latched on an accepted `start`.
  - `fill_value`, in, 32: latched on an accepted `start`.
- Fill-mode behaviour (when the latched `fill`=1):
  - The RD state is skipped entirely and `src_addr` is ignored.
  - Each word is a WR of `fill_value` to `dst_ptr`.
  - Latency is 2 cycles per word with the standard responder, so `done` pulses in cycle 2N+1.
- When not defined: the ports do not exist and the block is copy-only, exactly as described above.

## Test plan

- Basic copy:
  - Preload mem[0x0010..0x0013]=0xA0..0xA3.
  - `start` with src=0x0010, dst=0x0100, len=4.
  - Required: mem[0x0100..0x0103]=0xA0..0xA3; `busy` high for cycles 1–16; `done` pulses in cycle 17 only.
- Zero length:
  - `start` with len=0.
  - Required: `done` in cycle 1, `mem_read`/`mem_write` never high, memory unchanged.
- Address wrap:
  - src=0xFFFE, dst=0x0200, len=3.
  - Required: reads in order 0xFFFE, 0xFFFF, 0x0000; writes to 0x0200–0x0202.
- Variable stall:
  - Responder model holds `mem_stall` high for 3 cycles per request.
  - Required: request and address stay stable through the stall, data is correct, and `done` is at cycle 8N+1 for N=2.
- Ignored start and mid-copy reset:
  - Pulse `start` with new operands during the second word of a len=4 copy. Required: operands are ignored.
  - Then assert `rst` during a WR stall. Required: all outputs are 0 on the next cycle, and only words already completed are written.
- Fill mode (`MEM_DMA_FILL_EN`):
  - fill=1, fill_value=0xDEADBEEF, dst=0x0040, len=5.
  - Required: mem[0x0040..0x0044]=0xDEADBEEF, no reads issued, `done` in cycle 11.

Source files
------------

// File: rtl/mem_copy_dma_if.sv
// Memory request/stall port between a DMA/CPU initiator (master) and the data memory (slave).
interface mem_copy_dma_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] mem_address;
   logic [31:0]      mem_data_out;
   logic             mem_read;
   logic             mem_write;
   logic [31:0]      mem_data_in;
   logic             mem_stall;

   modport master (
      output mem_address, mem_data_out, mem_read, mem_write,
      input  mem_data_in, mem_stall
   );

   modport slave (
      input  mem_address, mem_data_out, mem_read, mem_write,
      output mem_data_in, mem_stall
   );
endinterface

// File: rtl/mem_copy_dma.sv
// Block-copy initiator: alternating read/write per word, 4 cycles/word with a one-stall responder;
// requests are held unchanged while mem_stall is high. Optional fill mode under MEM_DMA_FILL_EN.
module mem_copy_dma #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] src_addr,
   input  logic [WIDTH-1:0] dst_addr,
   input  logic [WIDTH-1:0] len,
`ifdef MEM_DMA_FILL_EN
   input  logic             fill,
   input  logic [31:0]      fill_value,
`endif
   output logic             busy,
   output logic             done,
   mem_copy_dma_if.master   mem
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] src_ptr;
   logic [WIDTH-1:0] dst_ptr;
   logic [WIDTH-1:0] remaining;
   logic [31:0]      data_reg;
   logic             start_fill;
   logic             fill_mode;

`ifdef MEM_DMA_FILL_EN
   assign start_fill = fill;

   // Fill mode reuses data_reg as the constant write word, so RD is never visited.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_mode <= 1'b0;
      end else if (state == IDLE && start) begin
         fill_mode <= fill;
      end
   end
`else
   assign start_fill = 1'b0;
   assign fill_mode  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_nxt = DONE;
               end else if (start_fill) begin
                  state_nxt = WR;
               end else begin
                  state_nxt = RD;
               end
            end
         end
         RD: begin
            if (!mem.mem_stall) begin
               state_nxt = WR;
            end
         end
         WR: begin
            if (!mem.mem_stall) begin
               if (remaining == ONE) begin
                  state_nxt = DONE;
               end else if (fill_mode) begin
                  state_nxt = WR;
               end else begin
                  state_nxt = RD;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         data_reg  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_ptr   <= src_addr;
                  dst_ptr   <= dst_addr;
                  remaining <= len;
`ifdef MEM_DMA_FILL_EN
                  data_reg  <= fill_value;
`endif
               end
            end
            RD: begin
               if (!mem.mem_stall) begin
                  data_reg <= mem.mem_data_in;
                  src_ptr  <= src_ptr + ONE;
               end
            end
            WR: begin
               if (!mem.mem_stall) begin
                  dst_ptr   <= dst_ptr + ONE;
                  remaining <= remaining - ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are pure decodes of registered state, so mem_stall never reaches them combinationally.
   assign mem.mem_read     = (state == RD);
   assign mem.mem_write    = (state == WR);
   assign mem.mem_address  = (state == RD) ? src_ptr :
                             (state == WR) ? dst_ptr : '0;
   assign mem.mem_data_out = (state == WR) ? data_reg : 32'h0;
   assign busy             = (state == RD) || (state == WR);
   assign done             = (state == DONE);

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: directed table, hand-written reset sequence, random copies.
module tb_mem_copy_dma;
   localparam int W = 16;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] src_addr = '0;
   logic [W-1:0] dst_addr = '0;
   logic [W-1:0] len = '0;
   logic         busy;
   logic         done;
`ifdef MEM_DMA_FILL_EN
   logic         fill = 1'b0;
   logic [31:0]  fill_value = '0;
`endif

   mem_copy_dma_if #(.WIDTH(W)) bus ();

   mem_copy_dma #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
`ifdef MEM_DMA_FILL_EN
      .fill       (fill),
      .fill_value (fill_value),
`endif
      .busy       (busy),
      .done       (done),
      .mem        (bus)
   );

   // Responder: stalls each request for stall_n cycles, then completes it.
   logic [31:0] mem_arr [65536];
   logic [31:0] ref_mem [65536];
   int          stall_n = 1;
   int          stall_cnt = 0;

   assign bus.mem_stall   = (bus.mem_read || bus.mem_write) && (stall_cnt < stall_n);
   assign bus.mem_data_in = (bus.mem_read && !bus.mem_stall) ? mem_arr[bus.mem_address] : 32'hDEAD_0BAD;

   always @(posedge clk) begin
      if ((bus.mem_read || bus.mem_write) && bus.mem_stall) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
   end

   logic [W-1:0] rd_q[$];
   logic [W-1:0] wr_q[$];
   int           checks = 0;
   int           failures = 0;
   int           proto_viol = 0;
   bit           monitor_on = 1'b0;
   bit           prev_stalled = 1'b0;
   bit           prev_rst = 1'b0;
   logic [W+33:0] prev_sig = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [W-1:0] a, input logic [31:0] v);
      mem_arr[a] = v;
      ref_mem[a] = v;
   endtask

   // Called at a negedge: protocol monitor, logs completions, commits writes, advances one cycle.
   task automatic tick();
      bit req;
      logic [W+33:0] sig;
      req = (bus.mem_read === 1'b1) || (bus.mem_write === 1'b1);
      sig = {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_data_out};
      if (monitor_on) begin
         if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) proto_viol++;
         if (!req && (bus.mem_address !== '0 || bus.mem_data_out !== '0)) proto_viol++;
         if (prev_stalled && !prev_rst && sig !== prev_sig) proto_viol++;
      end
      prev_stalled = req && (bus.mem_stall === 1'b1);
      prev_rst     = rst;
      prev_sig     = sig;
      if (bus.mem_write === 1'b1 && bus.mem_stall === 1'b0) begin
         mem_arr[bus.mem_address] = bus.mem_data_out;
         wr_q.push_back(bus.mem_address);
      end
      if (bus.mem_read === 1'b1 && bus.mem_stall === 1'b0) rd_q.push_back(bus.mem_address);
      @(negedge clk);
   endtask

   task automatic compare_mem(input string name);
      int diffs = 0;
      int first_diff = -1;
      for (int i = 0; i < 65536; i++) begin
         if (mem_arr[i] !== ref_mem[i]) begin
            diffs++;
            if (first_diff < 0) first_diff = i;
         end
      end
      check({name, " mem_diffs"}, diffs, 0);
      if (diffs != 0) $display("  first differing word at 0x%0h", first_diff);
   endtask

   task automatic compare_q(input string name, input logic [W-1:0] got[$], input logic [W-1:0] exp[$]);
      check({name, " count"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
   endtask

   task automatic do_copy(input string name, input logic [W-1:0] s, input logic [W-1:0] d,
                          input logic [W-1:0] n, input int st, input bit f,
                          input logic [31:0] fv, input int exp_done);
      logic [W-1:0] exp_rd[$];
      logic [W-1:0] exp_wr[$];
      logic [W-1:0] a;
      int done_cyc = -1;
      int done_cnt = 0;
      int busy_cnt = 0;
      int busy_first = -1;
      int busy_last = -1;
      stall_n = st;
      // Reference: ascending word-by-word copy, so overlapping ranges propagate naturally.
      for (int i = 0; i < int'(n); i++) begin
         a = d + W'(i);
         exp_wr.push_back(a);
         if (f) begin
            ref_mem[a] = fv;
         end else begin
            exp_rd.push_back(s + W'(i));
            ref_mem[a] = ref_mem[s + W'(i)];
         end
      end
      rd_q.delete();
      wr_q.delete();
      start = 1'b1; src_addr = s; dst_addr = d; len = n;
`ifdef MEM_DMA_FILL_EN
      fill = f; fill_value = fv;
`endif
      tick();
      start = 1'b0;
      src_addr = W'($urandom); dst_addr = W'($urandom); len = W'($urandom);
      for (int cyc = 1; cyc <= exp_done + 8; cyc++) begin
         // A start presented during DONE must be ignored.
         start = (cyc == exp_done);
         if (cyc == exp_done) begin
            src_addr = W'($urandom); dst_addr = W'($urandom); len = W'($urandom_range(1, 3));
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (busy === 1'b1) begin
            busy_cnt++;
            busy_last = cyc;
            if (busy_first < 0) busy_first = cyc;
         end
         tick();
      end
      start = 1'b0;
      check({name, " done_cycle"}, done_cyc, exp_done);
      check({name, " done_pulses"}, done_cnt, 1);
      check({name, " busy_cycles"}, busy_cnt, exp_done - 1);
      if (exp_done > 1) begin
         check({name, " busy_first"}, busy_first, 1);
         check({name, " busy_last"}, busy_last, exp_done - 1);
      end
      compare_q({name, " reads"}, rd_q, exp_rd);
      compare_q({name, " writes"}, wr_q, exp_wr);
      compare_mem(name);
   endtask

   typedef struct {
      string        name;
      logic [W-1:0] src;
      logic [W-1:0] dst;
      logic [W-1:0] n;
      int           stall;
      int           exp_done;
   } vec_t;

   initial begin
      vec_t vecs[6];
      logic [W-1:0] rs, rd, rn;
      logic [W-1:0] exp_rd[$];
      logic [W-1:0] exp_wr[$];
      int rst_st, exp;
      bit rf;

      vecs[0] = '{"basic",    16'h0010, 16'h0100, 16'd4, 1, 17};
      vecs[1] = '{"zero_len", 16'h0020, 16'h0110, 16'd0, 1, 1};
      vecs[2] = '{"wrap",     16'hFFFE, 16'h0200, 16'd3, 1, 13};
      vecs[3] = '{"stall3",   16'h0050, 16'h0120, 16'd2, 3, 17};
      vecs[4] = '{"overlap",  16'h0030, 16'h0031, 16'd3, 1, 13};
      vecs[5] = '{"nostall",  16'h0060, 16'h0140, 16'd3, 0, 7};

      for (int i = 0; i < 65536; i++) preload(W'(i), 32'h5A00_0000 | 32'(i));
      for (int i = 0; i < 4; i++) preload(16'h0010 + W'(i), 32'hA0 + 32'(i));

      // Reset state
      repeat (3) tick();
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset mem_read", bus.mem_read, 0);
      check("reset mem_write", bus.mem_write, 0);
      check("reset mem_address", bus.mem_address, 0);
      check("reset mem_data_out", bus.mem_data_out, 0);
      rst = 1'b0;
      monitor_on = 1'b1;
      tick();

      foreach (vecs[i])
         do_copy(vecs[i].name, vecs[i].src, vecs[i].dst, vecs[i].n, vecs[i].stall, 1'b0, 32'h0, vecs[i].exp_done);
      for (int i = 0; i < 4; i++)
         check($sformatf("basic dst[%0d]", i), mem_arr[16'h0100 + W'(i)], 32'hA0 + 32'(i));

      // Start ignored mid-copy, then reset during the third word's write stall.
      stall_n = 1;
      for (int i = 0; i < 4; i++) preload(16'h0080 + W'(i), 32'hB0 + 32'(i));
      rd_q.delete();
      wr_q.delete();
      start = 1'b1; src_addr = 16'h0080; dst_addr = 16'h0300; len = 16'd4;
      tick();
      for (int cyc = 1; cyc <= 10; cyc++) begin
         start = (cyc == 6);
         if (cyc == 6) begin src_addr = 16'h0500; dst_addr = 16'h0600; len = 16'd1; end
         tick();
      end
      start = 1'b0;
      rst_st = (bus.mem_write === 1'b1 && bus.mem_stall === 1'b1) ? 1 : 0;
      check("abort in_wr_stall", rst_st, 1);
      check("abort wr_address", bus.mem_address, 16'h0302);
      rst = 1'b1;
      tick();
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort mem_read", bus.mem_read, 0);
      check("abort mem_write", bus.mem_write, 0);
      check("abort mem_address", bus.mem_address, 0);
      check("abort mem_data_out", bus.mem_data_out, 0);
      rst = 1'b0;
      tick();
      tick();
      ref_mem[16'h0300] = 32'hB0;
      ref_mem[16'h0301] = 32'hB1;
      exp_rd = '{16'h0080, 16'h0081, 16'h0082};
      exp_wr = '{16'h0300, 16'h0301};
      compare_q("abort reads", rd_q, exp_rd);
      compare_q("abort writes", wr_q, exp_wr);
      compare_mem("abort");

`ifdef MEM_DMA_FILL_EN
      do_copy("fill", 16'h1234, 16'h0040, 16'd5, 1, 1'b1, 32'hDEAD_BEEF, 11);
      for (int i = 0; i < 5; i++)
         check($sformatf("fill dst[%0d]", i), mem_arr[16'h0040 + W'(i)], 32'hDEAD_BEEF);
`endif

      for (int k = 0; k < 20; k++) begin
         rs = W'($urandom);
         rd = W'($urandom);
         rn = ($urandom_range(0, 7) == 0) ? 16'd0 : W'($urandom_range(1, 6));
         rst_st = $urandom_range(0, 3);
         rf = 1'b0;
`ifdef MEM_DMA_FILL_EN
         rf = 1'($urandom_range(0, 1));
`endif
         for (int i = 0; i < 6; i++) preload(rs + W'(i), $urandom);
         exp = (rn == 0) ? 1 : 1 + int'(rn) * (rf ? 1 : 2) * (rst_st + 1);
         do_copy($sformatf("rand%0d", k), rs, rd, rn, rst_st, rf, $urandom, exp);
      end

      check("protocol_violations", proto_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
